// File: rtl/keystream_xor_pkg.sv
// keystream_xor_pkg: state encoding, read-address field positions and block-size default
package keystream_xor_pkg;
  localparam int ADDR_W = 6;
  localparam int BLOCK_BYTES_DEF = 64;
  localparam int ROW_MSB = 5;
  localparam int ROW_LSB = 4;
  localparam int COL_MSB = 3;
  localparam int COL_LSB = 2;
  localparam int BYTE_MSB = 1;
  localparam int BYTE_LSB = 0;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [1:0] row, input logic [1:0] col, input logic [1:0] byt);
    return {row, col, byt};
  endfunction
endpackage

// File: rtl/keystream_xor_if.sv
// keystream_xor_if: quarter read bus, block handshake and input/output byte streams
interface keystream_xor_if;
  import keystream_xor_pkg::*;
  logic              block_valid;
  logic              block_done;
  logic              core_hold;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  modport master (
    output block_valid, rd_data, in_valid, in_data, out_ready,
    input  block_done, core_hold, rd_addr, in_ready, out_valid, out_data
  );
  modport slave (
    input  block_valid, rd_data, in_valid, in_data, out_ready,
    output block_done, core_hold, rd_addr, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/keystream_xor_byte_out_reg.sv
// keystream_xor_byte_out_reg: single-entry valid/ready byte register without skid buffer
module keystream_xor_byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       can_load_o
);
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  assign can_load_o = !valid_q || ready_i;
  assign valid_d = load_i || (valid_q && !ready_i);
  assign data_d = load_i ? data_i : data_q;
  assign valid_o = valid_q;
  assign data_o = data_q;
  // hold the byte until accepted; a new load may replace it in the accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/keystream_xor.sv
// keystream_xor: XORs a byte stream with a keystream block read from the quarters (flush port under KEYSTREAM_FLUSH_EN)
module keystream_xor
  import keystream_xor_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
) (
  input logic clk,
  input logic rst_n,
`ifdef KEYSTREAM_FLUSH_EN
  input logic flush,
`endif
  keystream_xor_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLOCK_BYTES - 1);
  state_e            state_q;
  logic [ADDR_W-1:0] n_q;
  logic              core_hold_q, block_done_q;
  logic              can_load, xfer, flush_hit, end_blk;
`ifdef KEYSTREAM_FLUSH_EN
  assign flush_hit = (state_q == STREAM) && flush;
`else
  assign flush_hit = 1'b0;
`endif
  assign bus.in_ready = (state_q == STREAM) && can_load;
  assign xfer = bus.in_valid && bus.in_ready;
  assign end_blk = (xfer && n_q == LAST) || flush_hit;
  assign bus.rd_addr = n_q;
  assign bus.core_hold = core_hold_q;
  assign bus.block_done = block_done_q;
  keystream_xor_byte_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (xfer),
    .data_i    (bus.in_data ^ bus.rd_data),
    .ready_i   (bus.out_ready),
    .valid_o   (bus.out_valid),
    .data_o    (bus.out_data),
    .can_load_o(can_load)
  );
  // block FSM: wait for a block, walk its bytes, then wait for block_valid to clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      core_hold_q  <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= end_blk;
      case (state_q)
        IDLE: if (bus.block_valid) begin
          state_q     <= STREAM;
          core_hold_q <= 1'b1;
        end
        STREAM: if (end_blk) begin
          state_q     <= WAIT_CLR;
          n_q         <= '0;
          core_hold_q <= 1'b0;
        end else if (xfer) n_q <= n_q + ADDR_W'(1);
        WAIT_CLR: if (!bus.block_valid) state_q <= IDLE;
        default: begin
          state_q     <= IDLE;
          n_q         <= '0;
          core_hold_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
